// File: rtl/fp_pkg.sv
// Shared constants and modular add/sub helpers for GF(p) arithmetic, p = 5*2^248 - 1.
package fp_pkg;

  localparam int FP_W    = 255;
  localparam int FOLD_SH = 248;
  localparam logic [FP_W-1:0] P_MOD = (255'd5 << FOLD_SH) - 255'd1;

  localparam int LAT_FP_MUL      = 4;
  localparam int LATENCY_FP2_SQR = 1 + LAT_FP_MUL;

  // Both operands canonical, so a single conditional subtract suffices.
  function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [FP_W:0] sm;
    sm = {1'b0, a} + {1'b0, b};
    return FP_W'((sm >= {1'b0, P_MOD}) ? sm - {1'b0, P_MOD} : sm);
  endfunction

  function automatic logic [FP_W-1:0] fp_sub(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [FP_W:0] df;
    df = {1'b0, a} - {1'b0, b};
    return df[FP_W] ? FP_W'(df) + P_MOD : FP_W'(df);
  endfunction

endpackage

// File: rtl/fp2_squarer_if.sv
// Operand/result bundle for fp2_squarer. FP2_SQR_VALID_EN adds in_valid/out_valid.
interface fp2_squarer_if;
  import fp_pkg::*;

  logic [FP_W-1:0] A1, B1, D1, D2;
`ifdef FP2_SQR_VALID_EN
  logic in_valid, out_valid;

  modport master (output A1, B1, in_valid, input  D1, D2, out_valid);
  modport slave  (input  A1, B1, in_valid, output D1, D2, out_valid);
`else
  modport master (output A1, B1, input  D1, D2);
  modport slave  (input  A1, B1, output D1, D2);
`endif
endinterface

// File: rtl/fp_mul_mod.sv
// Pipelined a*b mod p with reduction via p+1 = 5*2^248: X = q*(p+1) + r  =>  X == q + r.
// Stages: product, first fold, second fold, final subtract (+ optional extra output regs).
module fp_mul_mod
  import fp_pkg::*;
#(
  parameter int LAT = LAT_FP_MUL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] r_o
);

  localparam int PW  = 2 * FP_W;
  localparam int HW  = PW - FOLD_SH;
  localparam int YHW = HW - FOLD_SH;
  localparam int ZW  = FP_W + 1;
  localparam int OD  = LAT - 3;

  logic [PW-1:0]             prod_q, prod_d;
  logic [HW-1:0]             y_q, y_d;
  logic [ZW-1:0]             z_q, z_d;
  logic [OD-1:0][FP_W-1:0]   out_q, out_d;

  logic [HW-1:0]  hi, quo, rem;
  logic [YHW-1:0] y_hi, quo2, rem2;

  always_comb begin
    prod_d = PW'(a_i) * PW'(b_i);

    // First fold: split on 2^248, divide the high part by 5 to get the (p+1) quotient.
    hi  = prod_q[PW-1:FOLD_SH];
    quo = hi / HW'(5);
    rem = hi % HW'(5);
    y_d = quo + (rem << FOLD_SH) + HW'(prod_q[FOLD_SH-1:0]);

    // Second fold leaves at most p + 2^11, so one subtract finishes the job.
    y_hi = y_q[HW-1:FOLD_SH];
    quo2 = y_hi / YHW'(5);
    rem2 = y_hi % YHW'(5);
    z_d  = ZW'(quo2) + (ZW'(rem2) << FOLD_SH) + ZW'(y_q[FOLD_SH-1:0]);

    out_d    = '0;
    out_d[0] = FP_W'((z_q >= {1'b0, P_MOD}) ? z_q - {1'b0, P_MOD} : z_q);
    for (int i = 1; i < OD; i++) out_d[i] = out_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      y_q    <= '0;
      z_q    <= '0;
      out_q  <= '0;
    end else begin
      prod_q <= prod_d;
      y_q    <= y_d;
      z_q    <= z_d;
      out_q  <= out_d;
    end
  end

  assign r_o = out_q[OD-1];

endmodule

// File: rtl/fp2_squarer.sv
// GF(p^2) squarer: (A1 + B1 i)^2 = (A1+B1)(A1-B1) + 2*A1*B1 i, fully pipelined.
// Optional FP2_SQR_VALID_EN adds a valid bit carried alongside the data.
module fp2_squarer
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp2_squarer_if.slave io
);

  localparam int LATENCY_FP2_SQR = fp_pkg::LATENCY_FP2_SQR;
  localparam int NUM_MUL         = 2;

  logic [FP_W-1:0] s_q, s_d, d_q, d_d, t_q, t_d, b_q, b_d;
  logic [NUM_MUL-1:0][FP_W-1:0] mul_a, mul_b, mul_r;

  always_comb begin
    s_d = fp_add(io.A1, io.B1);
    d_d = fp_sub(io.A1, io.B1);
    t_d = fp_add(io.A1, io.A1);
    b_d = io.B1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      d_q <= '0;
      t_q <= '0;
      b_q <= '0;
    end else begin
      s_q <= s_d;
      d_q <= d_d;
      t_q <= t_d;
      b_q <= b_d;
    end
  end

  // Lane 0 produces the real part, lane 1 the imaginary part.
  assign mul_a = {t_q, s_q};
  assign mul_b = {b_q, d_q};

  for (genvar g = 0; g < NUM_MUL; g++) begin : g_mul
    fp_mul_mod #(.LAT(LATENCY_FP2_SQR - 1)) u_mul (
      .clk (clk),
      .rst (rst),
      .a_i (mul_a[g]),
      .b_i (mul_b[g]),
      .r_o (mul_r[g])
    );
  end

  assign io.D1 = mul_r[0];
  assign io.D2 = mul_r[1];

`ifdef FP2_SQR_VALID_EN
  logic [LATENCY_FP2_SQR-1:0] vld_pipe_q, vld_pipe_d;

  always_comb vld_pipe_d = {vld_pipe_q[LATENCY_FP2_SQR-2:0], io.in_valid};

  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  assign io.out_valid = vld_pipe_q[LATENCY_FP2_SQR-1];
`endif

endmodule

// File: tb/tb_fp2_squarer.sv
// Directed + random bench for fp2_squarer against a plain modular-arithmetic model.
module tb_fp2_squarer;

  localparam logic [254:0] P = (255'd5 << 248) - 255'd1;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp2_squarer_if sq_if();
  fp2_squarer dut (.clk(clk), .rst(rst), .io(sq_if));

  int n_chk = 0;
  int n_fail = 0;
  int ne = 0;
  int L;

  logic [254:0] ed1 [DEPTH];
  logic [254:0] ed2 [DEPTH];
  logic         ev  [DEPTH];
  logic         ek  [DEPTH];

  function automatic logic [254:0] m_d1(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] pp, aa, bb;
    pp = 512'(P);
    aa = (512'(a) * 512'(a)) % pp;
    bb = (512'(b) * 512'(b)) % pp;
    return 255'((aa + pp - bb) % pp);
  endfunction

  function automatic logic [254:0] m_d2(input logic [254:0] a, input logic [254:0] b);
    return 255'((512'(a) * 512'(b) * 512'd2) % 512'(P));
  endfunction

  function automatic logic [254:0] rnd();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return 255'(w % 256'(P));
  endfunction

  task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %h expected %h", tag, ne, obs, exp);
    end
  endtask

  // Drive one clock of inputs, record when its result is due, check what is due now.
  task automatic cycle(input logic r, input logic [254:0] a, input logic [254:0] b,
                       input logic [254:0] e1, input logic [254:0] e2, input logic v);
    @(negedge clk);
    rst      = r;
    sq_if.A1 = a;
    sq_if.B1 = b;
`ifdef FP2_SQR_VALID_EN
    sq_if.in_valid = v;
`endif
    @(posedge clk);
    ne++;
    if (r) begin
      for (int i = 0; i < L; i++) begin
        ed1[ne+i] = '0; ed2[ne+i] = '0; ev[ne+i] = 1'b0; ek[ne+i] = 1'b1;
      end
    end else begin
      ed1[ne+L-1] = e1; ed2[ne+L-1] = e2; ev[ne+L-1] = v; ek[ne+L-1] = 1'b1;
    end
    #1;
    if (ek[ne]) begin
      chk("D1", sq_if.D1, ed1[ne]);
      chk("D2", sq_if.D2, ed2[ne]);
`ifdef FP2_SQR_VALID_EN
      chk("out_valid", 255'(sq_if.out_valid), 255'(ev[ne]));
`endif
    end
  endtask

  task automatic rcycle(input logic r);
    logic [254:0] a, b;
    a = rnd();
    b = rnd();
    if ($urandom_range(0, 7) == 0) a = P - 255'd1;
    cycle(r, a, b, m_d1(a, b), m_d2(a, b), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [254:0] pm1;
    pm1 = P - 255'd1;
    L = dut.LATENCY_FP2_SQR;
    for (int i = 0; i < DEPTH; i++) ek[i] = 1'b0;
    sq_if.A1 = '0;
    sq_if.B1 = '0;
`ifdef FP2_SQR_VALID_EN
    sq_if.in_valid = 1'b0;
`endif

    cycle(1'b1, '0, '0, '0, '0, 1'b0);
    cycle(1'b1, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, '0, '0, 1'b1);

    cycle(1'b0, 255'd2, 255'd0, 255'd4, 255'd0, 1'b1);
    cycle(1'b0, 255'd0, 255'd1, pm1,    255'd0, 1'b1);
    cycle(1'b0, 255'd1, 255'd1, 255'd0, 255'd2, 1'b1);
    cycle(1'b0, pm1,    255'd0, 255'd1, 255'd0, 1'b1);
    cycle(1'b0, 255'd3, 255'd2, 255'd5, 255'd12, 1'b1);
    cycle(1'b0, pm1,    pm1,    255'd0, 255'd2, 1'b1);
    for (int i = 0; i < L; i++) cycle(1'b0, '0, '0, '0, '0, 1'b0);

    for (int i = 0; i < 40; i++) rcycle(1'b0);
    rcycle(1'b1);
    for (int i = 0; i < 20; i++) rcycle(1'b0);
    rcycle(1'b1);
    rcycle(1'b1);
    for (int i = 0; i < 10; i++) rcycle(1'b0);
    for (int i = 0; i < L; i++) cycle(1'b0, '0, '0, '0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
